serial_add_sub: RTL

Parametrised, digit-serial two's-complement adder/subtractor with a start/done handshake, the sequential successor to the team's 4-bit combinational add/sub. It takes two WIDTH-bit signed operands, processes DIGIT bits per clock cycle, and returns an exact sign-extended WIDTH+1-bit result together with carry and overflow flags. It sits between the lab register file or switch inputs and the display/result path, wherever area matters more than single-cycle latency.

---
 rtl/serial_add_sub_if.sv | 24 ++
 rtl/serial_add_sub.sv | 119 +++++++++++
 2 files changed

// File: rtl/serial_add_sub_if.sv
// Start/done handshake and operand/result bundle for serial_add_sub.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   result;
  logic             carry;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor. Consumes DIGIT bits of each
// operand per cycle, LSB first, and delivers a sign-extended WIDTH+1-bit exact
// result with carry and signed-overflow flags after WIDTH/DIGIT cycles.
module serial_add_sub #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIGIT = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_add_sub_if.slave bus
);

  if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             msb_a, msb_b;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   dsum;
  logic             cin_top;
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] sr_next;

  // Digit adder and the accumulator value after this cycle's digit is shifted in.
  always_comb begin
    dsum    = {1'b0, sa[DIGIT-1:0]} + {1'b0, sb[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
    // Carry into the digit's top bit recovered from its sum bit; on the last
    // digit this is c[WIDTH-1], needed for the overflow flag.
    cin_top = dsum[DIGIT-1] ^ sa[DIGIT-1] ^ sb[DIGIT-1];
    dig_ext = '0;
    dig_ext[DIGIT-1:0] = dsum[DIGIT-1:0];
    sr_next = (sr >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
  end

  // Control decode: when a start is taken and when the final digit is in flight.
  always_comb begin
    accept = bus.start && (state != RUN);
    last   = (cnt == CW'(N - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_n  = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_n = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_n  = bus.start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand shift registers, carry, digit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      c          <= 1'b0;
      cnt        <= '0;
      msb_a      <= 1'b0;
      msb_b      <= 1'b0;
      bus.result <= '0;
      bus.carry  <= 1'b0;
      bus.ovf    <= 1'b0;
    end else if (accept) begin
      sa    <= bus.a;
      sb    <= bus.b ^ {WIDTH{bus.sub}};
      sr    <= '0;
      c     <= bus.sub;
      cnt   <= '0;
      msb_a <= bus.a[WIDTH-1];
      msb_b <= bus.b[WIDTH-1] ^ bus.sub;
    end else if (state == RUN) begin
      sa  <= sa >> DIGIT;
      sb  <= sb >> DIGIT;
      sr  <= sr_next;
      c   <= dsum[DIGIT];
      cnt <= cnt + 1'b1;
      if (last) begin
        // Sign bit of the exact sum of the sign-extended operands.
        bus.result <= {msb_a ^ msb_b ^ dsum[DIGIT], sr_next};
        bus.carry  <= dsum[DIGIT];
        bus.ovf    <= dsum[DIGIT] ^ cin_top;
      end
    end
  end

endmodule
